// File: rtl/lab1_pkg.sv
// Shared types and constants for the Lab1 equivalence checker.
// The agreement test lives here so every block uses the same definition.
package lab1_pkg;

   localparam int NUM_VEC = 16;
   localparam int VEC_W   = 4;
   localparam int ERR_W   = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic logic outputs_agree(input logic [2:0] f);
      return (f[0] == f[1]) && (f[1] == f[2]);
   endfunction

endpackage

// File: rtl/lab1_vec_sequencer.sv
// Walks abcd through 0..15, holding each vector SETTLE_CYCLES cycles and
// flagging the final cycle of each hold as the sample point.
module lab1_vec_sequencer
   import lab1_pkg::*;
#(
   parameter int SETTLE_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic             run_i,
   output logic [VEC_W-1:0] abcd_o,
   output logic             sample_en_o,
   output logic             last_vec_o
);

   localparam logic [7:0] RELOAD = 8'(SETTLE_CYCLES - 1);

   logic [VEC_W-1:0] vec_q, vec_d;
   logic [7:0]       cnt_q, cnt_d;

   // NOTE: every variable gets its default first so no path leaves it unassigned (no latch).
   always_comb begin
      vec_d = vec_q;
      cnt_d = cnt_q;
      if (load_i) begin
         vec_d = '0;
         cnt_d = RELOAD;
      end else if (run_i) begin
         if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
         end else if (!last_vec_o) begin
            vec_d = vec_q + VEC_W'(1);
            cnt_d = RELOAD;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec_q <= '0;
         cnt_q <= 8'd0;
      end else begin
         vec_q <= vec_d;
         cnt_q <= cnt_d;
      end
   end

   assign abcd_o      = vec_q;
   assign sample_en_o = run_i && (cnt_q == 8'd0);
   assign last_vec_o  = (vec_q == VEC_W'(NUM_VEC - 1));

endmodule

// File: rtl/lab1_equiv_checker.sv
// Sweeps all 16 Lab1 input vectors and records where the gate-level,
// dataflow and UDP outputs disagree; pass is valid while done is high.
module lab1_equiv_checker
   import lab1_pkg::*;
#(
   parameter int SETTLE_CYCLES = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   output logic [VEC_W-1:0]     abcd,
   input  logic [2:0]           f_in,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [ERR_W-1:0]     err_count,
   output logic [VEC_W-1:0]     first_fail_vec,
   output logic                 first_fail_valid,
   output logic [NUM_VEC-1:0]   fail_map
);

   state_e               state_q, state_d;
   logic [ERR_W-1:0]     err_q, err_d;
   logic [VEC_W-1:0]     first_q, first_d;
   logic                 first_valid_q, first_valid_d;
   logic [NUM_VEC-1:0]   map_q, map_d;

   logic start_ok;
   logic sample_en;
   logic last_vec;
   logic run;

   // A start is only honoured from IDLE or DONE; during RUN it is dropped.
   assign start_ok = start && (state_q != RUN);
   assign run      = (state_q == RUN);

   lab1_vec_sequencer #(
      .SETTLE_CYCLES (SETTLE_CYCLES)
   ) u_seq (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_i      (start_ok),
      .run_i       (run),
      .abcd_o      (abcd),
      .sample_en_o (sample_en),
      .last_vec_o  (last_vec)
   );

   always_comb begin
      state_d       = state_q;
      err_d         = err_q;
      first_d       = first_q;
      first_valid_d = first_valid_q;
      map_d         = map_q;
      case (state_q)
         IDLE, DONE: begin
            if (start_ok) begin
               state_d       = RUN;
               err_d         = '0;
               first_d       = '0;
               first_valid_d = 1'b0;
               map_d         = '0;
            end
         end
         RUN: begin
            if (sample_en) begin
               if (!outputs_agree(f_in)) begin
                  map_d[abcd] = 1'b1;
                  err_d       = err_q + ERR_W'(1);
                  if (!first_valid_q) begin
                     first_d       = abcd;
                     first_valid_d = 1'b1;
                  end
               end
               if (last_vec) state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         err_q         <= '0;
         first_q       <= '0;
         first_valid_q <= 1'b0;
         map_q         <= '0;
      end else begin
         state_q       <= state_d;
         err_q         <= err_d;
         first_q       <= first_d;
         first_valid_q <= first_valid_d;
         map_q         <= map_d;
      end
   end

   assign busy             = (state_q == RUN);
   assign done             = (state_q == DONE);
   assign pass             = done && (err_q == '0);
   assign err_count        = err_q;
   assign first_fail_vec   = first_q;
   assign first_fail_valid = first_valid_q;
   assign fail_map         = map_q;

endmodule

// File: tb/tb_lab1_equiv_checker.sv
// Self-checking bench: per-vector output tables feed the checker and a
// table-level reference computes the expected sweep results.
module tb_lab1_equiv_checker;

   localparam int S = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic start_aux = 1'b0;

   always #5 clk = ~clk;

   logic [3:0]  abcd;
   logic [2:0]  f_in;
   logic        busy, done, pass;
   logic [4:0]  err_count;
   logic [3:0]  first_fail_vec;
   logic        first_fail_valid;
   logic [15:0] fail_map;

   logic [2:0]  tbl [16];
   assign f_in = tbl[abcd];

   lab1_equiv_checker #(.SETTLE_CYCLES(S)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abcd(abcd), .f_in(f_in),
      .busy(busy), .done(done), .pass(pass), .err_count(err_count),
      .first_fail_vec(first_fail_vec), .first_fail_valid(first_fail_valid),
      .fail_map(fail_map)
   );

   // Two extra instances with F1 delayed one cycle through a flop.
   function automatic logic gfun(input logic [3:0] v);
      return (v[3] & v[2]) | (v[1] ^ v[0]);
   endfunction

   logic [3:0]  abcd_s1, abcd_s2, ffv_s1, ffv_s2;
   logic [2:0]  f_s1, f_s2;
   logic        dly_s1, dly_s2;
   logic        busy_s1, done_s1, pass_s1, ffok_s1;
   logic        busy_s2, done_s2, pass_s2, ffok_s2;
   logic [4:0]  err_s1, err_s2;
   logic [15:0] map_s1, map_s2;

   always @(posedge clk) begin
      dly_s1 <= gfun(abcd_s1);
      dly_s2 <= gfun(abcd_s2);
   end
   assign f_s1 = {gfun(abcd_s1), gfun(abcd_s1), dly_s1};
   assign f_s2 = {gfun(abcd_s2), gfun(abcd_s2), dly_s2};

   lab1_equiv_checker #(.SETTLE_CYCLES(1)) dut_s1 (
      .clk(clk), .rst_n(rst_n), .start(start_aux), .abcd(abcd_s1), .f_in(f_s1),
      .busy(busy_s1), .done(done_s1), .pass(pass_s1), .err_count(err_s1),
      .first_fail_vec(ffv_s1), .first_fail_valid(ffok_s1), .fail_map(map_s1)
   );

   lab1_equiv_checker #(.SETTLE_CYCLES(2)) dut_s2 (
      .clk(clk), .rst_n(rst_n), .start(start_aux), .abcd(abcd_s2), .f_in(f_s2),
      .busy(busy_s2), .done(done_s2), .pass(pass_s2), .err_count(err_s2),
      .first_fail_vec(ffv_s2), .first_fail_valid(ffok_s2), .fail_map(map_s2)
   );

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: a vector fails when its three outputs are not all equal.
   logic [15:0] exp_map;
   int          exp_err;
   int          exp_first;

   task automatic build_model();
      exp_map   = '0;
      exp_err   = 0;
      exp_first = -1;
      for (int v = 0; v < 16; v++) begin
         if (!(tbl[v] == 3'b000 || tbl[v] == 3'b111)) begin
            exp_map[v] = 1'b1;
            exp_err++;
            if (exp_first < 0) exp_first = v;
         end
      end
   endtask

   task automatic fill_same();
      for (int v = 0; v < 16; v++) tbl[v] = {3{gfun(4'(v))}};
   endtask

   task automatic fill_stuck();
      for (int v = 0; v < 16; v++) tbl[v] = {1'b0, {2{(v == 15)}}};
   endtask

   task automatic fill_flip();
      logic g;
      for (int v = 0; v < 16; v++) begin
         g = gfun(4'(v));
         tbl[v] = {g, ((v == 3 || v == 9) ? ~g : g), g};
      end
   endtask

   task automatic fill_random();
      for (int v = 0; v < 16; v++) begin
         if ($urandom_range(0, 2) == 0) tbl[v] = 3'($urandom);
         else tbl[v] = {3{1'($urandom)}};
      end
   endtask

   // Called at a negedge; start is captured at the following posedge (edge k).
   task automatic sweep(input string name, input bit inject);
      build_model();
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      check({name, "_start_busy"}, busy, 1'b1);
      check({name, "_start_done"}, done, 1'b0);
      check({name, "_start_pass"}, pass, 1'b0);
      check({name, "_start_clr_err"}, err_count, 0);
      check({name, "_start_clr_map"}, fail_map, 0);
      check({name, "_start_clr_valid"}, first_fail_valid, 1'b0);
      check({name, "_start_abcd"}, abcd, 0);
      for (int e = 1; e < 16 * S; e++) begin
         @(posedge clk);
         @(negedge clk);
         check({name, "_abcd_hold"}, abcd, e / S);
         start = inject && (e == 4 || e == 29);
      end
      start = 1'b0;
      check({name, "_pre_done"}, done, 1'b0);
      check({name, "_pre_busy"}, busy, 1'b1);
      @(posedge clk);
      @(negedge clk);
      check({name, "_done"}, done, 1'b1);
      check({name, "_busy_low"}, busy, 1'b0);
      check({name, "_abcd_end"}, abcd, 15);
      check({name, "_err"}, err_count, exp_err);
      check({name, "_map"}, fail_map, exp_map);
      check({name, "_valid"}, first_fail_valid, exp_first >= 0);
      check({name, "_first"}, first_fail_vec, (exp_first >= 0) ? exp_first : 0);
      check({name, "_pass"}, pass, exp_err == 0);
      @(negedge clk);
      check({name, "_done_level"}, done, 1'b1);
   endtask

   initial begin
      fill_same();
      repeat (3) @(negedge clk);
      check("rst_abcd", abcd, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_pass", pass, 0);
      check("rst_err", err_count, 0);
      check("rst_first", first_fail_vec, 0);
      check("rst_valid", first_fail_valid, 0);
      check("rst_map", fail_map, 0);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);

      sweep("same", 1'b0);
      check("same_map_const", fail_map, 16'h0000);

      fill_stuck();
      sweep("stuck", 1'b1);
      check("stuck_err_const", err_count, 1);
      check("stuck_first_const", first_fail_vec, 15);
      check("stuck_map_const", fail_map, 16'h8000);

      fill_flip();
      sweep("flip", 1'b0);
      check("flip_err_const", err_count, 2);
      check("flip_first_const", first_fail_vec, 3);
      check("flip_map_const", fail_map, 16'h0208);

      fill_same();
      sweep("rerun", 1'b1);

      for (int i = 0; i < 4; i++) begin
         fill_random();
         sweep("rand", i[0]);
      end

      start_aux = 1'b1;
      @(negedge clk);
      start_aux = 1'b0;
      repeat (40) @(negedge clk);
      check("s1_done", done_s1, 1'b1);
      check("s1_has_mismatch", err_s1 != 0, 1'b1);
      check("s1_pass", pass_s1, 1'b0);
      check("s2_done", done_s2, 1'b1);
      check("s2_err", err_s2, 0);
      check("s2_pass", pass_s2, 1'b1);

      // Reset in the middle of a sweep with failures already recorded.
      for (int v = 0; v < 16; v++) tbl[v] = 3'b001;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      begin
         int guard = 0;
         while (abcd != 4'd7 && guard < 200) begin
            @(negedge clk);
            guard++;
         end
         check("reach_vec7", abcd == 4'd7, 1'b1);
      end
      check("mid_busy", busy, 1'b1);
      check("mid_err_nonzero", err_count != 0, 1'b1);
      #1 rst_n = 1'b0;
      #1;
      check("arst_abcd", abcd, 0);
      check("arst_busy", busy, 0);
      check("arst_done", done, 0);
      check("arst_err", err_count, 0);
      check("arst_first", first_fail_vec, 0);
      check("arst_valid", first_fail_valid, 0);
      check("arst_map", fail_map, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      fill_random();
      sweep("post_rst", 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
